// File: rtl/stream_packetizer_pkg.sv
// stream_pkg: shared FSM encoding, sync-byte default and sizing helpers for the stream packetizer
package stream_pkg;

    // Packet phases; CSUM is only entered when the checksum trailer is built in
    typedef enum logic [2:0] {IDLE, SYNC, SRC, DATA, CSUM} state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h00;

    // Number of whole bytes needed to carry a w-bit sample
    function automatic int bytes_per_sample(input int w);
        return (w + 7) / 8;
    endfunction

    // Index width for n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_packetizer_if.sv
// stream_packetizer_if: sample-queue side and write-queue side signals of the packetizer
interface stream_packetizer_if #(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 10
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        em;
    logic [NUM_CH-1:0]        pp;
    logic [7:0]               out_write;
    logic                     ld_write;
    logic                     full_write;
    logic                     busy;

    modport master (
        input  in_data, em, full_write,
        output pp, out_write, ld_write, busy
    );

    modport slave (
        output in_data, em, full_write,
        input  pp, out_write, ld_write, busy
    );
endinterface

// File: rtl/stream_packetizer_rr_arbiter.sv
// rr_arbiter: combinational round-robin search over req starting just after ptr, wrapping modulo N
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int N  = 5,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k]) begin
                gnt     = '0;
                gnt[(int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k] = 1'b1;
                gnt_idx = PW'((int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_packetizer.sv
// stream_packetizer: drains NUM_CH FWFT sample queues into an 8-bit write queue as framed packets
// (sync, source ID, little-endian sample bytes); STREAM_PKT_CHECKSUM_EN appends an XOR trailer byte.
module stream_packetizer
    import stream_pkg::*;
#(
    parameter int         NUM_CH    = 5,
    parameter int         DATA_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    stream_packetizer_if.master bus
);

    localparam int NB = bytes_per_sample(DATA_W);
    localparam int BW = clog2_min1(NB);
    localparam int PW = clog2_min1(NUM_CH);

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [BW-1:0]       idx_q, idx_d;
    logic [NB*8-1:0]     buf_q, buf_d;
    logic [7:0]          src_q, src_d;
    logic [7:0]          out_q, out_d;
    logic [NUM_CH-1:0]   pp_q, pp_d;
    logic                ld_q, ld_d;
    logic                busy_q, busy_d;
`ifdef STREAM_PKT_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic [NUM_CH-1:0]   gnt;
    logic [PW-1:0]       gnt_idx;
    logic                any;
    logic [DATA_W-1:0]   sample;
    logic [7:0]          cur_byte;

    rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
        .req     (~bus.em),
        .ptr     (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Select the granted channel's sample and the buffered byte due for output
    always_comb begin
        sample   = '0;
        cur_byte = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (gnt_idx == PW'(i)) sample = bus.in_data[i*DATA_W +: DATA_W];
        for (int k = 0; k < NB; k++)
            if (idx_q == BW'(k)) cur_byte = buf_q[k*8 +: 8];
    end

    // Packet FSM: each byte is issued only when the write queue reported room at this edge
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        src_d   = src_q;
        out_d   = out_q;
        pp_d    = '0;
        ld_d    = 1'b0;
        busy_d  = busy_q;
`ifdef STREAM_PKT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: if (any) begin
                buf_d   = (NB*8)'(sample);
                pp_d    = gnt;
                src_d   = 8'(int'(gnt_idx) + 1);
                rr_d    = gnt_idx;
                busy_d  = 1'b1;
                state_d = SYNC;
            end
            SYNC: if (!bus.full_write) begin
                out_d   = SYNC_BYTE;
                ld_d    = 1'b1;
                state_d = SRC;
            end
            SRC: if (!bus.full_write) begin
                out_d   = src_q;
                ld_d    = 1'b1;
                idx_d   = '0;
                state_d = DATA;
`ifdef STREAM_PKT_CHECKSUM_EN
                csum_d  = src_q;
`endif
            end
            DATA: if (!bus.full_write) begin
                out_d = cur_byte;
                ld_d  = 1'b1;
`ifdef STREAM_PKT_CHECKSUM_EN
                csum_d = csum_q ^ cur_byte;
`endif
                if (idx_q == BW'(NB - 1)) begin
`ifdef STREAM_PKT_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`ifdef STREAM_PKT_CHECKSUM_EN
            CSUM: if (!bus.full_write) begin
                out_d   = csum_q;
                ld_d    = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= PW'(NUM_CH - 1);
            idx_q   <= '0;
            buf_q   <= '0;
            src_q   <= '0;
            out_q   <= '0;
            pp_q    <= '0;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            src_q   <= src_d;
            out_q   <= out_d;
            pp_q    <= pp_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
        end
    end

`ifdef STREAM_PKT_CHECKSUM_EN
    // Running XOR of source ID and data bytes for the trailer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`endif

    assign bus.pp        = pp_q;
    assign bus.out_write = out_q;
    assign bus.ld_write  = ld_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_stream_packetizer.sv
// tb_stream_packetizer: table-driven and randomized checks of stream_packetizer against a queue-level model
module tb_stream_packetizer;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int         ch;
        logic [9:0] s;
        int         stall;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_packetizer_if #(.NUM_CH(5), .DATA_W(10)) b0();
    stream_packetizer_if #(.NUM_CH(3), .DATA_W(16)) b1();
    stream_packetizer_if #(.NUM_CH(1), .DATA_W(4))  b2();

    stream_packetizer #(.NUM_CH(5), .DATA_W(10)) u0 (.clk(clk), .rst(rst), .bus(b0.master));
    stream_packetizer #(.NUM_CH(3), .DATA_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1.master));
    stream_packetizer #(.NUM_CH(1), .DATA_W(4))  u2 (.clk(clk), .rst(rst), .bus(b2.master));

    int         nvec = 0;
    int         nerr = 0;
    logic [9:0] q[5][$];
    bq_t        cap, cap1, cap2, exp_b;
    int         grants[$];
    int         exp_g[$];
    int         mp;
    logic [4:0] pend;
    logic       pend1, pend2;
    vec_t       tv[5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmpq(input string nm, input bq_t act, input bq_t exp);
        check({nm, "_len"}, 64'(act.size()), 64'(exp.size()));
        for (int k = 0; k < act.size() && k < exp.size(); k++)
            check($sformatf("%s[%0d]", nm, k), 64'(act[k]), 64'(exp[k]));
    endtask

    task automatic cmp_grants();
        check("grant_count", 64'(grants.size()), 64'(exp_g.size()));
        for (int k = 0; k < grants.size() && k < exp_g.size(); k++)
            check($sformatf("grant[%0d]", k), 64'(grants[k]), 64'(exp_g[k]));
    endtask

    // Expected byte stream of one packet: sync, ID, little-endian sample bytes, optional XOR trailer
    function automatic bq_t pkt(input int ch, input logic [63:0] s, input int nb);
        bq_t        r;
        logic [7:0] x;
        x = 8'(ch + 1);
        r.push_back(8'h00);
        r.push_back(x);
        for (int k = 0; k < nb; k++) begin
            r.push_back(8'(s >> (8 * k)));
            x = x ^ 8'(s >> (8 * k));
        end
`ifdef STREAM_PKT_CHECKSUM_EN
        r.push_back(x);
`endif
        return r;
    endfunction

    // Round-robin reference: next non-empty queue after the last grant, wrapping
    task automatic model_drain();
        logic [9:0] mq[5][$];
        int g;
        bq_t t;
        exp_b.delete();
        exp_g.delete();
        for (int i = 0; i < 5; i++) mq[i] = q[i];
        do begin
            g = -1;
            for (int k = 1; k <= 5 && g < 0; k++)
                if (mq[(mp + k) % 5].size() != 0) g = (mp + k) % 5;
            if (g >= 0) begin
                exp_g.push_back(g);
                t = pkt(g, 64'(mq[g][0]), 2);
                foreach (t[k]) exp_b.push_back(t[k]);
                void'(mq[g].pop_front());
                mp = g;
            end
        end while (g >= 0);
    endtask

    task automatic refresh();
        for (int i = 0; i < 5; i++) begin
            b0.em[i] = (q[i].size() == 0);
            b0.in_data[i*10 +: 10] = (q[i].size() != 0) ? q[i][0] : 10'h0;
        end
    endtask

    // One clock: queues pop on the edge after a pp pulse; outputs sampled 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 5; i++)
            if (pend[i] && q[i].size() != 0) void'(q[i].pop_front());
        if (pend1) b1.em = '1;
        if (pend2) b2.em = '1;
        #2;
        pend  = b0.pp;
        pend1 = |b1.pp;
        pend2 = |b2.pp;
        if (b0.pp != '0) begin
            check("pp_onehot", 64'($onehot(b0.pp)), 64'd1);
            for (int i = 0; i < 5; i++) if (b0.pp[i]) grants.push_back(i);
        end
        if (b0.ld_write) begin
            check("ld_while_full", 64'(b0.full_write), 64'd0);
            cap.push_back(b0.out_write);
        end
        if (b1.ld_write) cap1.push_back(b1.out_write);
        if (b2.ld_write) cap2.push_back(b2.out_write);
        refresh();
    endtask

    task automatic run(input bit randfull);
        int  t;
        logic done;
        t = 0;
        cap.delete();
        grants.delete();
        do begin
            tick();
            b0.full_write = randfull ? ($urandom_range(0, 3) == 0) : 1'b0;
            t++;
            done = (pend == '0) && !b0.busy;
            for (int i = 0; i < 5; i++) if (q[i].size() != 0) done = 1'b0;
        end while (!done && t < 3000);
        b0.full_write = 1'b0;
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: got %0d cycles, required completion", t);
        end
        repeat (3) tick();
    endtask

    initial begin
        int  t0, hold, sz;
        bq_t e;
        tv[0] = '{2, 10'h2A5, -1, 8'hA5, 8'h02};
        tv[1] = '{2, 10'h2A5,  2, 8'hA5, 8'h02};
        tv[2] = '{0, 10'h3FF,  0, 8'hFF, 8'h03};
        tv[3] = '{4, 10'h001,  1, 8'h01, 8'h00};
        tv[4] = '{1, 10'h100,  3, 8'h00, 8'h01};
        pend = '0; pend1 = 1'b0; pend2 = 1'b0;
        b0.full_write = 1'b0; b1.full_write = 1'b0; b2.full_write = 1'b0;
        b1.em = '1; b1.in_data = '0;
        b2.em = '1; b2.in_data = '0;
        refresh();
        repeat (2) @(posedge clk);
        #2;
        check("rst_pp",   64'(b0.pp),        64'd0);
        check("rst_out",  64'(b0.out_write), 64'd0);
        check("rst_ld",   64'(b0.ld_write),  64'd0);
        check("rst_busy", 64'(b0.busy),      64'd0);
        rst = 1'b0;
        mp  = 4;

        // All five queues hold two samples from reset
        for (int i = 0; i < 5; i++)
            repeat (2) q[i].push_back(10'($urandom));
        refresh();
        model_drain();
        run(1'b0);
        cmpq("all5_bytes", cap, exp_b);
        cmp_grants();

        // Single-packet table with write-queue stalls at chosen offsets after the pp pulse
        for (int n = 0; n < 5; n++) begin
            cap.delete();
            grants.delete();
            q[tv[n].ch].push_back(tv[n].s);
            refresh();
            t0 = -1;
            hold = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (t0 < 0 && grants.size() != 0) t0 = c;
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) b0.full_write = 1'b0;
                end else if (t0 >= 0 && c - t0 == tv[n].stall) begin
                    b0.full_write = 1'b1;
                    hold = 4;
                end
            end
            e = '{8'h00, 8'(tv[n].ch + 1), tv[n].d0, tv[n].d1};
`ifdef STREAM_PKT_CHECKSUM_EN
            e.push_back(8'(tv[n].ch + 1) ^ tv[n].d0 ^ tv[n].d1);
`endif
            cmpq($sformatf("vec%0d", n), cap, e);
            exp_g = '{tv[n].ch};
            cmp_grants();
            check("busy_after", 64'(b0.busy), 64'd0);
            mp = tv[n].ch;
        end

        // Reset while the source byte is pending: popped sample is lost, arbitration restarts at channel 0
        cap.delete();
        grants.delete();
        q[1].push_back(10'h111);
        q[3].push_back(10'h033);
        q[4].push_back(10'h2F0);
        refresh();
        for (int c = 0; c < 10 && grants.size() == 0; c++) tick();
        check("rst_test_grant", 64'(grants.size() != 0 ? grants[0] : -1), 64'd3);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_pp",   64'(b0.pp),        64'd0);
        check("midrst_out",  64'(b0.out_write), 64'd0);
        check("midrst_ld",   64'(b0.ld_write),  64'd0);
        check("midrst_busy", 64'(b0.busy),      64'd0);
        pend = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        mp  = 4;
        refresh();
        model_drain();
        run(1'b0);
        cmpq("after_rst", cap, exp_b);
        cmp_grants();

        // Randomized fills with random write-queue backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 5; i++) begin
                sz = $urandom_range(0, 3);
                repeat (sz) q[i].push_back(10'($urandom));
            end
            refresh();
            model_drain();
            run(1'b1);
            cmpq($sformatf("rand%0d", r), cap, exp_b);
            cmp_grants();
        end

        // Wide and narrow samples on the alternative instances
        cap1.delete();
        cap2.delete();
        b1.in_data[15:0] = 16'hBEEF;
        b1.em = 3'b110;
        b2.in_data = 4'h9;
        b2.em = 1'b0;
        repeat (12) tick();
        cmpq("w16", cap1, pkt(0, 64'hBEEF, 2));
        cmpq("w4",  cap2, pkt(0, 64'h9, 1));
        check("w16_busy", 64'(b1.busy), 64'd0);
        check("w4_busy",  64'(b2.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
